tw_addr_gen: RTL

Twiddle address sequencer for one radix-2^2 SDF stage. Counts accepted samples of a frame, computes the twiddle exponent for each sample position, and drives the address port of that stage's twiddle ROM. It also produces a valid strobe aligned with the ROM output, so the complex multiplier sees data and twiddle in the same cycle. One instance sits beside each stage's butterfly pair and ROM.

---
 rtl/tw_addr_gen.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/tw_addr_gen.sv
//==============================================================================
// Module   : tw_addr_gen
// Twiddle ROM address sequencer for one radix-2^2 SDF stage.
// Optional feature macro: TW_UNITY_EN (adds o_tw_unity, twiddle == 1+j0 flag).
// Revision : 1.0
//==============================================================================
`default_nettype none

`ifndef FFT_POINTS
`define FFT_POINTS 64
`endif
`ifndef C2LOG_FFT_POINTS
`define C2LOG_FFT_POINTS 6
`endif

module tw_addr_gen #(
    parameter int LOG_M = `C2LOG_FFT_POINTS,
    parameter int TW_FF = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_di_en,
    input  logic                         i_clr,
    output logic [`C2LOG_FFT_POINTS-1:0] o_tw_addr,
    output logic                         o_addr_vld,
    output logic                         o_tw_vld,
    output logic                         o_frame_done,
`ifdef TW_UNITY_EN
    output logic                         o_tw_unity,
`endif
    output logic                         o_busy
);

    localparam int             c_A     = `C2LOG_FFT_POINTS;
    localparam int             c_N     = `FFT_POINTS;
    localparam int             c_SHIFT = c_A - LOG_M;
    localparam int             c_PW    = (LOG_M > 2) ? LOG_M - 2 : 1;
    localparam logic [c_A-1:0] c_LAST  = c_A'(c_N - 1);
    localparam logic [c_A-1:0] c_ONE   = c_A'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_A-1:0]   r_cnt;
    logic [c_A-1:0]   w_cnt_nxt;
    logic [c_A-1:0]   r_tw_addr;
    logic             r_addr_vld;
    logic             r_frame_done;

    logic             w_accept;
    logic             w_last;
    logic [LOG_M-1:0] w_n;
    logic [1:0]       w_q;
    logic [c_PW-1:0]  w_p;
    logic [LOG_M-1:0] w_p_ext;
    logic [LOG_M-1:0] w_e;
    logic [c_A-1:0]   w_e_ext;
    logic [c_A-1:0]   w_addr;

    assign w_accept = i_di_en & ~i_clr;
    assign w_last   = w_accept & (r_cnt == c_LAST);

    // Exponent from the pre-increment count: e = p * sel(q), sel = {0,2,1,3}.
    assign w_n = r_cnt[LOG_M-1:0];
    assign w_q = w_n[LOG_M-1:LOG_M-2];

    generate
        if (LOG_M > 2) begin : g_p_wide
            assign w_p = w_n[LOG_M-3:0];
        end else begin : g_p_zero
            assign w_p = '0;
        end
    endgenerate

    assign w_p_ext = LOG_M'(w_p);

    always_comb begin
        w_e = '0;
        case (w_q)
            2'd0:    w_e = '0;
            2'd1:    w_e = w_p_ext << 1;
            2'd2:    w_e = w_p_ext;
            default: w_e = w_p_ext + (w_p_ext << 1);
        endcase
    end

    assign w_e_ext = c_A'(w_e);
    assign w_addr  = w_e_ext << c_SHIFT;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_clr) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (i_di_en) begin
            w_cnt_nxt = w_last ? '0 : r_cnt + c_ONE;
            case (r_state)
                S_IDLE:  w_state_nxt = w_last ? S_IDLE : S_RUN;
                S_RUN:   w_state_nxt = w_last ? S_IDLE : S_RUN;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_tw_addr    <= '0;
            r_addr_vld   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_addr_vld   <= w_accept;
            r_frame_done <= w_last;
            if (w_accept) begin
                r_tw_addr <= w_addr;
            end
        end
    end

    // The ROM output stage is mirrored here; clr kills a valid already in flight.
    generate
        if (TW_FF == 0) begin : g_tw_ff0
            assign o_tw_vld = r_addr_vld;
        end else begin : g_tw_ff1
            logic r_tw_vld;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tw_vld <= 1'b0;
                end else begin
                    r_tw_vld <= r_addr_vld & ~i_clr;
                end
            end
            assign o_tw_vld = r_tw_vld;
        end
    endgenerate

`ifdef TW_UNITY_EN
    logic r_unity_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_unity_a <= 1'b0;
        end else if (w_accept) begin
            r_unity_a <= (w_addr == '0);
        end
    end

    generate
        if (TW_FF == 0) begin : g_unity_ff0
            assign o_tw_unity = r_unity_a;
        end else begin : g_unity_ff1
            logic r_unity_d;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_unity_d <= 1'b0;
                end else begin
                    r_unity_d <= r_unity_a;
                end
            end
            assign o_tw_unity = r_unity_d;
        end
    endgenerate
`endif

    assign o_tw_addr    = r_tw_addr;
    assign o_addr_vld   = r_addr_vld;
    assign o_frame_done = r_frame_done;
    assign o_busy       = (r_state == S_RUN);

endmodule

`default_nettype wire
